// File: rtl/tiny_rv_pipe_ctrl.sv
// tiny_rv_pipe_ctrl
// Hazard and sequencing controller for a small in-order RISC-V pipeline.
// Arbitrates taken branches, data-memory waits and load-use hazards, and
// drives stall / flush / bubble / redirect into the front-end stages.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   RUN      | normal issue; branch > memory wait > load-use arbitration
//   MEM_WAIT | execute holds a data-memory request awaiting ack
//   FLUSH    | second flush cycle after a taken branch / jump
//
// Control outputs are combinational from state and inputs so a hazard is
// acted on in the same cycle it is seen. Only the FSM state, the memory
// timeout counter, the sticky timeout flag and the stall-cycle counter are
// registered. Encoding 3 is never entered and behaves as RUN.

module tiny_rv_pipe_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_dec_valid,
    input  logic [6:0]  i_dec_opcode,
    input  logic [4:0]  i_dec_rs1,
    input  logic [4:0]  i_dec_rs2,
    input  logic        i_ex_is_load,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_branch_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_mem_req,
    input  logic        i_mem_ack,
    output logic        o_pipe_stall,
    output logic        o_pipe_flush,
    output logic        o_bubble,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic [1:0]  o_state,
    output logic        o_mem_timeout,
    output logic [31:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_RSVD     = 2'd3
    } state_t;

    // RV32I major opcodes that read source registers
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [7:0]  TO_LAST  = 8'hFF;
    localparam logic [31:0] SC_MAX   = 32'hFFFF_FFFF;

    state_t      r_state;
    logic [7:0]  r_to_cnt;
    logic        r_mem_timeout;
    logic [31:0] r_stall_cycles;

    logic        w_rs1_used;
    logic        w_rs2_used;
    logic        w_load_use;

    state_t      w_state_next;
    logic        w_stall;
    logic        w_flush;
    logic        w_bubble;
    logic        w_redir_valid;
    logic [31:0] w_redir_pc;
    logic        w_to_clr;
    logic        w_to_inc;
    logic        w_to_set;

    // Which source fields the decode-stage opcode actually reads
    always_comb begin
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (i_dec_opcode)
            OP_JALR,
            OP_LOAD,
            OP_IMM: begin
                w_rs1_used = 1'b1;
            end
            OP_BRANCH,
            OP_STORE,
            OP_REG: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            default: begin
                w_rs1_used = 1'b0;
                w_rs2_used = 1'b0;
            end
        endcase
    end

    // x0 never carries a hazard, so rd==0 loads are excluded
    assign w_load_use = i_dec_valid & i_ex_is_load & (i_ex_rd != 5'd0) &
                        ((w_rs1_used & (i_dec_rs1 == i_ex_rd)) |
                         (w_rs2_used & (i_dec_rs2 == i_ex_rd)));

    // Next-state and same-cycle control decode
    always_comb begin
        w_state_next  = ST_RUN;
        w_stall       = 1'b0;
        w_flush       = 1'b0;
        w_bubble      = 1'b0;
        w_redir_valid = 1'b0;
        w_redir_pc    = 32'd0;
        w_to_clr      = 1'b0;
        w_to_inc      = 1'b0;
        w_to_set      = 1'b0;
        case (r_state)
            ST_MEM_WAIT: begin
                if (i_mem_ack) begin
                    w_state_next = ST_RUN;
                end else if (r_to_cnt == TO_LAST) begin
                    // give up on the access so the pipe cannot deadlock
                    w_to_set     = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_stall      = 1'b1;
                    w_to_inc     = 1'b1;
                    w_state_next = ST_MEM_WAIT;
                end
            end
            ST_FLUSH: begin
                // branch and memory inputs belong to squashed work here
                w_flush      = 1'b1;
                w_state_next = ST_RUN;
            end
            default: begin
                if (i_ex_branch_taken) begin
                    w_flush       = 1'b1;
                    w_redir_valid = 1'b1;
                    w_redir_pc    = i_ex_target;
                    w_state_next  = ST_FLUSH;
                end else if (i_mem_req && !i_mem_ack) begin
                    w_stall      = 1'b1;
                    w_to_clr     = 1'b1;
                    w_state_next = ST_MEM_WAIT;
                end else if (w_load_use) begin
                    w_stall      = 1'b1;
                    w_bubble     = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
        endcase
    end

    // Reset overrides every control output without waiting for a clock
    assign o_pipe_stall     = w_stall       & ~i_reset;
    assign o_pipe_flush     = w_flush       & ~i_reset;
    assign o_bubble         = w_bubble      & ~i_reset;
    assign o_redirect_valid = w_redir_valid & ~i_reset;
    assign o_redirect_pc    = i_reset ? 32'd0 : w_redir_pc;

    assign o_state          = r_state;
    assign o_mem_timeout    = r_mem_timeout;
    assign o_stall_cycles   = r_stall_cycles;

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Memory-wait timeout counter, restarted on every entry to MEM_WAIT
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_to_cnt <= 8'd0;
        end else if (w_to_clr) begin
            r_to_cnt <= 8'd0;
        end else if (w_to_inc) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    // Sticky timeout flag, only cleared by reset
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mem_timeout <= 1'b0;
        end else if (w_to_set) begin
            r_mem_timeout <= 1'b1;
        end
    end

    // Saturating count of cycles spent with the front end stalled
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cycles <= 32'd0;
        end else if (o_pipe_stall && (r_stall_cycles != SC_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

endmodule
